// File: rtl/sync_pulse_gen.sv
// Periodic sync/strobe generator with phase-offset taps, free-run/one-shot/burst
// sequencing, explicit stop and a one-cycle completion pulse.
module sync_pulse_gen #(
  parameter int PERIOD   = 4,
  parameter int PULSE_W  = 1,
  parameter int NUM_TAPS = 2,
  parameter int BURST_W  = 8,
  localparam int CW      = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [BURST_W-1:0]     burst_len,
  input  logic [NUM_TAPS*CW-1:0] tap_offset,
  output logic                   sync,
  output logic [NUM_TAPS-1:0]    tap,
  output logic [CW-1:0]          phase,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] LAST_PHASE = CW'(PERIOD - 1);
  localparam logic [CW-1:0] PW         = CW'(PULSE_W);
  localparam logic [1:0]    MODE_ONE   = 2'd1;
  localparam logic [1:0]    MODE_BURST = 2'd2;

  state_t               state, nxt_state;
  logic [CW-1:0]        phase_q, nxt_phase;
  logic [BURST_W-1:0]   pcount, nxt_pcount;
  logic [1:0]           mode_q, nxt_mode;
  logic [BURST_W-1:0]   blen_q, nxt_blen;
  logic                 done_q, nxt_done;
  logic                 sync_q, sync_nxt;
  logic [NUM_TAPS-1:0]  tap_q, tap_nxt;
  logic [BURST_W-1:0]   blen_eff;
  logic                 burst_last;
  logic                 terminate;

  // A burst length of zero behaves like one; the +1 compare is widened so a
  // saturated period count can never alias back to a small burst length.
  always_comb begin
    blen_eff   = (blen_q == '0) ? BURST_W'(1) : blen_q;
    burst_last = ({1'b0, pcount} + 1'b1) == {1'b0, blen_eff};
    case (mode_q)
      MODE_ONE:   terminate = 1'b1;
      MODE_BURST: terminate = burst_last;
      default:    terminate = 1'b0;
    endcase
  end

  // Next-state decode; start beats stop, stop beats the wrap-time termination.
  always_comb begin
    nxt_state  = state;
    nxt_phase  = phase_q;
    nxt_pcount = pcount;
    nxt_mode   = mode_q;
    nxt_blen   = blen_q;
    nxt_done   = 1'b0;
    if (start) begin
      nxt_state  = RUN;
      nxt_phase  = '0;
      nxt_pcount = '0;
      nxt_mode   = mode;
      nxt_blen   = burst_len;
    end else if (stop) begin
      nxt_state = IDLE;
      nxt_phase = '0;
    end else if (state == RUN) begin
      if (phase_q == LAST_PHASE) begin
        nxt_phase = '0;
        if (terminate) begin
          nxt_state = IDLE;
          nxt_done  = 1'b1;
        end else if (pcount != '1) begin
          nxt_pcount = pcount + 1'b1;
        end
      end else begin
        nxt_phase = phase_q + 1'b1;
      end
    end
  end

  // Strobes are decoded one cycle early from the next state so they leave a flop.
  always_comb begin
    tap_nxt  = '0;
    sync_nxt = (nxt_state == RUN) && (nxt_phase < PW);
    for (int i = 0; i < NUM_TAPS; i++) begin
      tap_nxt[i] = (nxt_state == RUN) && (nxt_phase == tap_offset[i*CW +: CW]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase_q <= '0;
      pcount  <= '0;
      mode_q  <= '0;
      blen_q  <= '0;
      done_q  <= 1'b0;
      sync_q  <= 1'b0;
      tap_q   <= '0;
    end else if (en) begin
      state   <= nxt_state;
      phase_q <= nxt_phase;
      pcount  <= nxt_pcount;
      mode_q  <= nxt_mode;
      blen_q  <= nxt_blen;
      done_q  <= nxt_done;
      sync_q  <= sync_nxt;
      tap_q   <= tap_nxt;
    end
  end

  assign sync  = sync_q;
  assign tap   = tap_q;
  assign phase = phase_q;
  assign busy  = (state == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Scoreboard bench for sync_pulse_gen at PERIOD=6, PULSE_W=2 so that tap offsets
// at or beyond the period are representable.
module tb_sync_pulse_gen;

  localparam int PERIOD   = 6;
  localparam int PULSE_W  = 2;
  localparam int NUM_TAPS = 2;
  localparam int BURST_W  = 8;
  localparam int CW       = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   start;
  logic                   stop;
  logic [1:0]             mode;
  logic [BURST_W-1:0]     burst_len;
  logic [NUM_TAPS*CW-1:0] tap_offset;
  logic                   sync;
  logic [NUM_TAPS-1:0]    tap;
  logic [CW-1:0]          phase;
  logic                   busy;
  logic                   done;

  sync_pulse_gen #(
    .PERIOD(PERIOD), .PULSE_W(PULSE_W), .NUM_TAPS(NUM_TAPS), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode),
    .burst_len(burst_len), .tap_offset(tap_offset), .sync(sync), .tap(tap),
    .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] e_phase;
    logic       e_busy;
    logic       e_sync;
    logic [1:0] e_tap;
    logic       e_done;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic checkOutput(string name, string field, logic [7:0] actual, logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, actual, expected);
    end
  endtask

  // One enabled-or-not clock edge: drive inputs, then queue what must appear after it.
  task automatic applyStimulus(string name, logic i_en, logic i_start, logic i_stop,
                               logic [1:0] i_mode, logic [7:0] i_bl,
                               logic [2:0] e_phase, logic e_busy, logic e_sync,
                               logic [1:0] e_tap, logic e_done);
    exp_t e;
    en        = i_en;
    start     = i_start;
    stop      = i_stop;
    mode      = i_mode;
    burst_len = i_bl;
    @(posedge clk);
    #1;
    e.name    = name;
    e.e_phase = e_phase;
    e.e_busy  = e_busy;
    e.e_sync  = e_sync;
    e.e_tap   = e_tap;
    e.e_done  = e_done;
    sb.push_back(e);
  endtask

  task automatic checkIdleNow(string name);
    checkOutput(name, "sync", 8'(sync), 8'd0);
    checkOutput(name, "tap", 8'(tap), 8'd0);
    checkOutput(name, "phase", 8'(phase), 8'd0);
    checkOutput(name, "busy", 8'(busy), 8'd0);
    checkOutput(name, "done", 8'(done), 8'd0);
  endtask

  // Monitor: every falling edge with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e.name, "phase", 8'(phase), 8'(e.e_phase));
        checkOutput(e.name, "busy", 8'(busy), 8'(e.e_busy));
        checkOutput(e.name, "sync", 8'(sync), 8'(e.e_sync));
        checkOutput(e.name, "tap", 8'(tap), 8'(e.e_tap));
        checkOutput(e.name, "done", 8'(done), 8'(e.e_done));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    mode       = 2'd0;
    burst_len  = 8'd0;
    tap_offset = {3'd7, 3'd2};
    repeat (2) @(posedge clk);
    #1;
    checkIdleNow("reset");
    rst = 1'b0;

    // Free-run; tap0 at phase 2, tap1 offset 7 lies beyond the period.
    applyStimulus("fr_start", 1, 1, 0, 2'd0, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    applyStimulus("fr_p1",    1, 0, 0, 2'd2, 8'd0, 3'd1, 1, 1, 2'b00, 0);
    applyStimulus("fr_p2",    1, 0, 0, 2'd0, 8'd0, 3'd2, 1, 0, 2'b01, 0);
    applyStimulus("fr_p3",    1, 0, 0, 2'd0, 8'd0, 3'd3, 1, 0, 2'b00, 0);
    applyStimulus("fr_p4",    1, 0, 0, 2'd0, 8'd0, 3'd4, 1, 0, 2'b00, 0);
    applyStimulus("fr_p5",    1, 0, 0, 2'd0, 8'd0, 3'd5, 1, 0, 2'b00, 0);
    applyStimulus("fr_wrap",  1, 0, 0, 2'd0, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    applyStimulus("fr_p1b",   1, 0, 0, 2'd0, 8'd0, 3'd1, 1, 1, 2'b00, 0);
    for (int k = 0; k < 5; k++)
      applyStimulus("en_hold", 0, 1, 0, 2'd0, 8'd0, 3'd1, 1, 1, 2'b00, 0);
    applyStimulus("en_resume", 1, 0, 0, 2'd0, 8'd0, 3'd2, 1, 0, 2'b01, 0);
    applyStimulus("restart",   1, 1, 0, 2'd0, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    applyStimulus("rs_p1",     1, 0, 0, 2'd0, 8'd0, 3'd1, 1, 1, 2'b00, 0);
    applyStimulus("start_stop", 1, 1, 1, 2'd0, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    applyStimulus("stop",      1, 0, 1, 2'd0, 8'd0, 3'd0, 0, 0, 2'b00, 0);
    applyStimulus("stop_idle", 1, 0, 1, 2'd0, 8'd0, 3'd0, 0, 0, 2'b00, 0);
    applyStimulus("idle",      1, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 2'b00, 0);

    // Reserved mode runs like free-run through a wrap.
    applyStimulus("m3_start", 1, 1, 0, 2'd3, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    for (int p = 1; p < 6; p++)
      applyStimulus("m3_run", 1, 0, 0, 2'd3, 8'd0, 3'(p), 1, (p < 2), (p == 2) ? 2'b01 : 2'b00, 0);
    applyStimulus("m3_wrap", 1, 0, 0, 2'd3, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    applyStimulus("m3_stop", 1, 0, 1, 2'd0, 8'd0, 3'd0, 0, 0, 2'b00, 0);

    // One-shot with both taps on phase 1; mode input changed mid-run is ignored.
    tap_offset = {3'd1, 3'd1};
    applyStimulus("os_start", 1, 1, 0, 2'd1, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    for (int p = 1; p < 6; p++)
      applyStimulus("os_run", 1, 0, 0, 2'd0, 8'd0, 3'(p), 1, (p < 2), (p == 1) ? 2'b11 : 2'b00, 0);
    applyStimulus("os_done", 1, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 2'b00, 1);
    applyStimulus("done_hold", 0, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 2'b00, 1);
    applyStimulus("done_hold", 0, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 2'b00, 1);
    applyStimulus("done_clr",  1, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 2'b00, 0);

    // Burst of two periods; burst_len input changed mid-run is ignored.
    applyStimulus("b2_start", 1, 1, 0, 2'd2, 8'd2, 3'd0, 1, 1, 2'b00, 0);
    for (int p = 1; p < 12; p++)
      applyStimulus("b2_run", 1, 0, 0, 2'd2, 8'd9, 3'(p % 6), 1, ((p % 6) < 2), ((p % 6) == 1) ? 2'b11 : 2'b00, 0);
    applyStimulus("b2_done", 1, 0, 0, 2'd2, 8'd9, 3'd0, 0, 0, 2'b00, 1);

    // Burst length zero behaves as a single period.
    applyStimulus("b0_start", 1, 1, 0, 2'd2, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    for (int p = 1; p < 6; p++)
      applyStimulus("b0_run", 1, 0, 0, 2'd2, 8'd0, 3'(p), 1, (p < 2), (p == 1) ? 2'b11 : 2'b00, 0);
    applyStimulus("b0_done", 1, 0, 0, 2'd2, 8'd0, 3'd0, 0, 0, 2'b00, 1);

    // Start on the final burst wrap restarts without done.
    applyStimulus("b1_start", 1, 1, 0, 2'd2, 8'd1, 3'd0, 1, 1, 2'b00, 0);
    for (int p = 1; p < 6; p++)
      applyStimulus("b1_run", 1, 0, 0, 2'd2, 8'd1, 3'(p), 1, (p < 2), (p == 1) ? 2'b11 : 2'b00, 0);
    applyStimulus("b1_restart", 1, 1, 0, 2'd2, 8'd1, 3'd0, 1, 1, 2'b00, 0);
    for (int p = 1; p < 6; p++)
      applyStimulus("b1_rerun", 1, 0, 0, 2'd2, 8'd1, 3'(p), 1, (p < 2), (p == 1) ? 2'b11 : 2'b00, 0);
    applyStimulus("b1_done", 1, 0, 0, 2'd2, 8'd1, 3'd0, 0, 0, 2'b00, 1);

    // Asynchronous reset mid-run clears outputs at once; a start is needed afterwards.
    applyStimulus("ar_start", 1, 1, 0, 2'd0, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    applyStimulus("ar_p1",    1, 0, 0, 2'd0, 8'd0, 3'd1, 1, 1, 2'b11, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkIdleNow("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("ar_idle",    1, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 2'b00, 0);
    applyStimulus("ar_restart", 1, 1, 0, 2'd0, 8'd0, 3'd0, 1, 1, 2'b00, 0);
    applyStimulus("ar_p1b",     1, 0, 0, 2'd0, 8'd0, 3'd1, 1, 1, 2'b11, 0);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard", "pending", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
